// File: rtl/key_conditioner_if.sv
// Key bundle between the board push-buttons and the conditioner: raw keys in,
// press strobes and held levels out.
interface key_conditioner_if #(
   parameter int unsigned NUM_KEYS = 4
);
   logic [NUM_KEYS-1:0] buttons;
   logic [NUM_KEYS-1:0] pressed;
   logic [NUM_KEYS-1:0] held;

   modport master (output buttons, input pressed, input held);
   modport slave  (input buttons, output pressed, output held);
endinterface

// File: rtl/key_conditioner.sv
// Push-button front-end: 2-FF synchroniser, per-key debounce FSM, one-cycle
// press pulses and optional auto-repeat while a key is held.
module key_conditioner #(
   parameter int unsigned         NUM_KEYS        = 4,
   parameter int unsigned         DEBOUNCE_CYCLES = 1000000,
   parameter int unsigned         REPEAT_DELAY    = 25000000,
   parameter int unsigned         REPEAT_PERIOD   = 5000000,
   parameter logic [NUM_KEYS-1:0] REPEAT_MASK     = NUM_KEYS'(4'b1000)
) (
   input logic               clk,
   input logic               reset,
   key_conditioner_if.slave  kif
);

   localparam int unsigned MAX_A   = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
   localparam int unsigned MAX_CYC = (MAX_A > REPEAT_PERIOD) ? MAX_A : REPEAT_PERIOD;
   localparam int unsigned CNT_W   = $clog2(MAX_CYC);

   localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DELAY - 1);
   localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPEAT_PERIOD - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_PRESS_WAIT,
      S_HELD,
      S_REPEAT,
      S_RELEASE_WAIT
   } state_t;

   logic [NUM_KEYS-1:0] r_sync1;
   logic [NUM_KEYS-1:0] r_sync2;
   logic [NUM_KEYS-1:0] r_pressed;
   logic [NUM_KEYS-1:0] r_held;
   logic [NUM_KEYS-1:0] w_pulse;
   logic [NUM_KEYS-1:0] w_held_nxt;

   state_t           r_state     [NUM_KEYS];
   state_t           w_state_nxt [NUM_KEYS];
   logic [CNT_W-1:0] r_cnt       [NUM_KEYS];
   logic [CNT_W-1:0] w_cnt_nxt   [NUM_KEYS];

   // State, counters, synchroniser and output registers; synchroniser resets to released
   always_ff @(posedge clk) begin
      if (reset) begin
         r_sync1   <= '1;
         r_sync2   <= '1;
         r_pressed <= '0;
         r_held    <= '0;
         for (int i = 0; i < int'(NUM_KEYS); i++) begin
            r_state[i] <= S_IDLE;
            r_cnt[i]   <= '0;
         end
      end else begin
         r_sync1   <= kif.buttons;
         r_sync2   <= r_sync1;
         r_pressed <= w_pulse;
         r_held    <= w_held_nxt;
         for (int i = 0; i < int'(NUM_KEYS); i++) begin
            r_state[i] <= w_state_nxt[i];
            r_cnt[i]   <= w_cnt_nxt[i];
         end
      end
   end

   // Per-key next state, counter and pulse; keys never interact
   always_comb begin
      w_pulse    = '0;
      w_held_nxt = '0;
      for (int i = 0; i < int'(NUM_KEYS); i++) begin
         w_state_nxt[i] = r_state[i];
         w_cnt_nxt[i]   = r_cnt[i];

         case (r_state[i])
            S_IDLE: begin
               if (!r_sync2[i]) begin
                  w_state_nxt[i] = S_PRESS_WAIT;
                  w_cnt_nxt[i]   = '0;
               end
            end
            S_PRESS_WAIT: begin
               if (r_sync2[i]) begin
                  w_state_nxt[i] = S_IDLE;
                  w_cnt_nxt[i]   = '0;
               end else if (r_cnt[i] == DEB_LAST) begin
                  w_state_nxt[i] = S_HELD;
                  w_cnt_nxt[i]   = '0;
                  w_pulse[i]     = 1'b1;
               end else begin
                  w_cnt_nxt[i] = r_cnt[i] + CNT_ONE;
               end
            end
            S_HELD: begin
               if (r_sync2[i]) begin
                  w_state_nxt[i] = S_RELEASE_WAIT;
                  w_cnt_nxt[i]   = '0;
               end else if (REPEAT_MASK[i]) begin
                  if (r_cnt[i] == DLY_LAST) begin
                     w_state_nxt[i] = S_REPEAT;
                     w_cnt_nxt[i]   = '0;
                     w_pulse[i]     = 1'b1;
                  end else begin
                     w_cnt_nxt[i] = r_cnt[i] + CNT_ONE;
                  end
               end else begin
                  w_cnt_nxt[i] = '0;
               end
            end
            S_REPEAT: begin
               if (r_sync2[i]) begin
                  w_state_nxt[i] = S_RELEASE_WAIT;
                  w_cnt_nxt[i]   = '0;
               end else if (r_cnt[i] == PER_LAST) begin
                  w_cnt_nxt[i] = '0;
                  w_pulse[i]   = 1'b1;
               end else begin
                  w_cnt_nxt[i] = r_cnt[i] + CNT_ONE;
               end
            end
            S_RELEASE_WAIT: begin
               // a release bounce goes back to HELD, restarting the repeat delay
               if (!r_sync2[i]) begin
                  w_state_nxt[i] = S_HELD;
                  w_cnt_nxt[i]   = '0;
               end else if (r_cnt[i] == DEB_LAST) begin
                  w_state_nxt[i] = S_IDLE;
                  w_cnt_nxt[i]   = '0;
               end else begin
                  w_cnt_nxt[i] = r_cnt[i] + CNT_ONE;
               end
            end
            default: begin
               w_state_nxt[i] = S_IDLE;
               w_cnt_nxt[i]   = '0;
            end
         endcase

         w_held_nxt[i] = (w_state_nxt[i] == S_HELD)   ||
                         (w_state_nxt[i] == S_REPEAT) ||
                         (w_state_nxt[i] == S_RELEASE_WAIT);
      end
   end

   assign kif.pressed = r_pressed;
   assign kif.held    = r_held;

endmodule

// File: tb/tb_key_conditioner.sv
// Directed bench for key_conditioner with short debounce/repeat timings.
module tb_key_conditioner;

   localparam int unsigned NUM_KEYS = 4;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   int   n_checks = 0;
   int   n_errors = 0;

   key_conditioner_if #(.NUM_KEYS(NUM_KEYS)) kif ();

   key_conditioner #(
      .NUM_KEYS        (NUM_KEYS),
      .DEBOUNCE_CYCLES (4),
      .REPEAT_DELAY    (10),
      .REPEAT_PERIOD   (3),
      .REPEAT_MASK     (4'b1000)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .kif   (kif)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Pulse edges for key 3 relative to its first sampled press
   int p3 [13] = '{6, 16, 19, 22, 25, 28, 31, 34, 37, 40, 54, 57, 60};

   initial begin
      logic [3:0] exp_p;
      logic [3:0] exp_h;

      kif.buttons = 4'b1111;
      reset = 1'b1;
      repeat (3) tick();
      check("reset pressed", 32'(kif.pressed), 32'h0);
      check("reset held", 32'(kif.held), 32'h0);
      reset = 1'b0;

      // All released: nothing happens
      for (int j = 0; j < 50; j++) begin
         kif.buttons = 4'b1111;
         tick();
         check($sformatf("idle j=%0d", j), 32'({kif.pressed, kif.held}), 32'h0);
      end

      // Key 0 held (no repeat), then released at edge 40
      for (int j = 0; j < 53; j++) begin
         kif.buttons = (j < 40) ? 4'b1110 : 4'b1111;
         tick();
         exp_p = (j == 6) ? 4'b0001 : 4'b0000;
         exp_h = (j >= 6 && j <= 45) ? 4'b0001 : 4'b0000;
         check($sformatf("k0 pressed j=%0d", j), 32'(kif.pressed), 32'(exp_p));
         if (j != 46)
            check($sformatf("k0 held j=%0d", j), 32'(kif.held), 32'(exp_h));
      end

      // Key 0 bouncing every 2 cycles: never accepted
      for (int j = 0; j < 40; j++) begin
         kif.buttons = (j < 30 && ((j / 2) % 2 == 0)) ? 4'b1110 : 4'b1111;
         tick();
         check($sformatf("bounce j=%0d", j), 32'({kif.pressed, kif.held}), 32'h0);
      end

      // Key 3 auto-repeat, bounce to 1 at edges 40-41, release from edge 61
      for (int j = 0; j < 80; j++) begin
         kif.buttons = ((j >= 40 && j <= 41) || j >= 61) ? 4'b1111 : 4'b0111;
         tick();
         exp_p = 4'b0000;
         foreach (p3[k]) if (p3[k] == j) exp_p = 4'b1000;
         exp_h = (j >= 6 && j <= 66) ? 4'b1000 : 4'b0000;
         check($sformatf("k3 pressed j=%0d", j), 32'(kif.pressed), 32'(exp_p));
         if (j != 67)
            check($sformatf("k3 held j=%0d", j), 32'(kif.held), 32'(exp_h));
      end

      // Keys 1 and 2 together, reset at edges 3-4, clean press afterwards
      for (int j = 0; j < 21; j++) begin
         kif.buttons = 4'b1001;
         reset = (j == 3 || j == 4);
         tick();
         exp_p = (j == 11) ? 4'b0110 : 4'b0000;
         exp_h = (j >= 11) ? 4'b0110 : 4'b0000;
         check($sformatf("k12 pressed j=%0d", j), 32'(kif.pressed), 32'(exp_p));
         check($sformatf("k12 held j=%0d", j), 32'(kif.held), 32'(exp_h));
      end
      reset = 1'b0;
      kif.buttons = 4'b1111;
      repeat (10) tick();
      check("final held", 32'(kif.held), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
